// File: rtl/rx_pkt_sequencer.sv
// Receive-path sequencer: steps through preamble, header and payload, aborts on
// disable/tx/timeout, pulses the core reset and keeps good/bad packet statistics.
module rx_pkt_sequencer #(
    parameter int RST_CYCLES = 4,
    parameter int TMO_WIDTH  = 16
) (
    input  logic                 s00_axi_aclk,
    input  logic                 s00_axi_aresetn,
    input  logic                 cfg_enable,
    input  logic [TMO_WIDTH-1:0] cfg_timeout,
    input  logic                 tx_busy,
    input  logic                 short_preamble_detected,
    input  logic                 long_preamble_detected,
    input  logic                 pkt_header_valid_strobe,
    input  logic                 pkt_header_valid,
    input  logic                 ht_unsupport,
    input  logic [15:0]          pkt_len,
    input  logic                 byte_out_strobe,
    input  logic                 fcs_out_strobe,
    input  logic                 fcs_ok,
    output logic                 core_rst,
    output logic                 core_enable,
    output logic [2:0]           rx_state,
    output logic [15:0]          pkt_len_latched,
    output logic                 pkt_done_strobe,
    output logic [2:0]           pkt_status,
    output logic [15:0]          pkt_count_ok,
    output logic [15:0]          pkt_count_err
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_LONG  = 3'd1,
        ST_WAIT_HDR   = 3'd2,
        ST_RECV       = 3'd3,
        ST_RESET_CORE = 3'd4
    } state_t;

    localparam logic [2:0] STS_FCS_OK  = 3'd0;
    localparam logic [2:0] STS_FCS_BAD = 3'd1;
    localparam logic [2:0] STS_HDR_BAD = 3'd2;
    localparam logic [2:0] STS_HT_UNS  = 3'd3;
    localparam logic [2:0] STS_TIMEOUT = 3'd4;
    localparam logic [2:0] STS_TX_ABRT = 3'd5;
    localparam logic [2:0] STS_DISABLE = 3'd6;

    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    state_t               state, next_state;
    logic [TMO_WIDTH-1:0] timer;
    logic                 tmo_armed;
    logic [RW-1:0]        rst_cnt;

    logic       load_timer;
    logic       latch_len;
    logic       term;
    logic [2:0] term_code;
    logic       tmo_hit;
    logic       next_in_pkt;

    // The timer only counts as expired if it was loaded with a nonzero limit.
    assign tmo_hit     = tmo_armed && (timer == '0);
    assign next_in_pkt = (next_state == ST_WAIT_LONG) || (next_state == ST_WAIT_HDR) ||
                         (next_state == ST_RECV);
    assign rx_state    = state;

    always_comb begin
        next_state = state;
        load_timer = 1'b0;
        latch_len  = 1'b0;
        term       = 1'b0;
        term_code  = STS_FCS_OK;
        case (state)
            ST_IDLE: begin
                if (short_preamble_detected && cfg_enable && !tx_busy) begin
                    next_state = ST_WAIT_LONG;
                    load_timer = 1'b1;
                end
            end
            ST_WAIT_LONG, ST_WAIT_HDR, ST_RECV: begin
                if (!cfg_enable) begin
                    next_state = ST_RESET_CORE;
                    term       = 1'b1;
                    term_code  = STS_DISABLE;
                end else if (tx_busy) begin
                    next_state = ST_RESET_CORE;
                    term       = 1'b1;
                    term_code  = STS_TX_ABRT;
                end else if (state == ST_WAIT_LONG && long_preamble_detected) begin
                    next_state = ST_WAIT_HDR;
                    load_timer = 1'b1;
                end else if (state == ST_WAIT_HDR && pkt_header_valid_strobe) begin
                    if (!pkt_header_valid) begin
                        next_state = ST_RESET_CORE;
                        term       = 1'b1;
                        term_code  = STS_HDR_BAD;
                    end else if (ht_unsupport) begin
                        next_state = ST_RESET_CORE;
                        term       = 1'b1;
                        term_code  = STS_HT_UNS;
                    end else begin
                        next_state = ST_RECV;
                        load_timer = 1'b1;
                        latch_len  = 1'b1;
                    end
                end else if (state == ST_RECV && fcs_out_strobe) begin
                    next_state = ST_IDLE;
                    term       = 1'b1;
                    term_code  = fcs_ok ? STS_FCS_OK : STS_FCS_BAD;
                end else if (state == ST_RECV && byte_out_strobe) begin
                    load_timer = 1'b1;
                end else if (tmo_hit) begin
                    next_state = ST_RESET_CORE;
                    term       = 1'b1;
                    term_code  = STS_TIMEOUT;
                end
            end
            ST_RESET_CORE: begin
                if (rst_cnt == '0) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state           <= ST_IDLE;
            timer           <= '0;
            tmo_armed       <= 1'b0;
            rst_cnt         <= '0;
            core_rst        <= 1'b0;
            core_enable     <= 1'b0;
            pkt_done_strobe <= 1'b0;
            pkt_status      <= STS_FCS_OK;
            pkt_len_latched <= '0;
            pkt_count_ok    <= '0;
            pkt_count_err   <= '0;
        end else begin
            state <= next_state;

            if (load_timer) begin
                timer     <= cfg_timeout;
                tmo_armed <= (cfg_timeout != '0);
            end else begin
                if (timer != '0) timer <= timer - TMO_WIDTH'(1);
                if (!next_in_pkt) tmo_armed <= 1'b0;
            end

            // Counter is preloaded so the reset state lasts exactly RST_CYCLES cycles.
            if (state != ST_RESET_CORE && next_state == ST_RESET_CORE)
                rst_cnt <= RW'(RST_CYCLES - 1);
            else if (rst_cnt != '0)
                rst_cnt <= rst_cnt - RW'(1);

            core_rst    <= (next_state == ST_RESET_CORE);
            core_enable <= cfg_enable && !tx_busy && (next_state != ST_RESET_CORE);

            if (latch_len) pkt_len_latched <= pkt_len;

            pkt_done_strobe <= term;
            if (term) begin
                pkt_status <= term_code;
                if (term_code == STS_FCS_OK) begin
                    if (pkt_count_ok != 16'hFFFF) pkt_count_ok <= pkt_count_ok + 16'd1;
                end else if (term_code != STS_DISABLE) begin
                    if (pkt_count_err != 16'hFFFF) pkt_count_err <= pkt_count_err + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rx_pkt_sequencer.sv
// Bench for rx_pkt_sequencer: directed scenarios plus randomized packets checked
// against a transaction-level model of termination status and statistics.
`timescale 1ns/1ps
module tb_rx_pkt_sequencer;
    localparam int RST_CYCLES = 4;
    localparam int TMO_WIDTH  = 16;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 cfg_enable;
    logic [TMO_WIDTH-1:0] cfg_timeout;
    logic                 tx_busy;
    logic                 short_preamble_detected;
    logic                 long_preamble_detected;
    logic                 pkt_header_valid_strobe;
    logic                 pkt_header_valid;
    logic                 ht_unsupport;
    logic [15:0]          pkt_len;
    logic                 byte_out_strobe;
    logic                 fcs_out_strobe;
    logic                 fcs_ok;
    logic                 core_rst;
    logic                 core_enable;
    logic [2:0]           rx_state;
    logic [15:0]          pkt_len_latched;
    logic                 pkt_done_strobe;
    logic [2:0]           pkt_status;
    logic [15:0]          pkt_count_ok;
    logic [15:0]          pkt_count_err;

    always #5 clk = ~clk;

    rx_pkt_sequencer #(.RST_CYCLES(RST_CYCLES), .TMO_WIDTH(TMO_WIDTH)) dut (
        .s00_axi_aclk            (clk),
        .s00_axi_aresetn         (rst_n),
        .cfg_enable              (cfg_enable),
        .cfg_timeout             (cfg_timeout),
        .tx_busy                 (tx_busy),
        .short_preamble_detected (short_preamble_detected),
        .long_preamble_detected  (long_preamble_detected),
        .pkt_header_valid_strobe (pkt_header_valid_strobe),
        .pkt_header_valid        (pkt_header_valid),
        .ht_unsupport            (ht_unsupport),
        .pkt_len                 (pkt_len),
        .byte_out_strobe         (byte_out_strobe),
        .fcs_out_strobe          (fcs_out_strobe),
        .fcs_ok                  (fcs_ok),
        .core_rst                (core_rst),
        .core_enable             (core_enable),
        .rx_state                (rx_state),
        .pkt_len_latched         (pkt_len_latched),
        .pkt_done_strobe         (pkt_done_strobe),
        .pkt_status              (pkt_status),
        .pkt_count_ok            (pkt_count_ok),
        .pkt_count_err           (pkt_count_err)
    );

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int rst_hi = 0;
    logic [2:0] last_status = 3'd7;
    int exp_ok = 0;
    int exp_err = 0;

    // Observed termination events, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (pkt_done_strobe) begin
                done_cnt++;
                last_status = pkt_status;
            end
            if (core_rst) rst_hi++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic gap();
        tick($urandom_range(0, 3));
    endtask

    task automatic pulse_short();
        short_preamble_detected = 1'b1; tick(); short_preamble_detected = 1'b0;
    endtask

    task automatic pulse_long();
        long_preamble_detected = 1'b1; tick(); long_preamble_detected = 1'b0;
    endtask

    task automatic pulse_hdr(input logic valid, input logic ht, input logic [15:0] len);
        pkt_header_valid = valid; ht_unsupport = ht; pkt_len = len;
        pkt_header_valid_strobe = 1'b1; tick();
        pkt_header_valid_strobe = 1'b0; ht_unsupport = 1'b0;
    endtask

    task automatic pulse_byte();
        byte_out_strobe = 1'b1; tick(); byte_out_strobe = 1'b0;
    endtask

    task automatic pulse_fcs(input logic ok);
        fcs_ok = ok; fcs_out_strobe = 1'b1; tick(); fcs_out_strobe = 1'b0;
    endtask

    // Reference statistics: status 0 is good, 1..5 are errors, 6 is not counted.
    task automatic model_term(input int status);
        if (status == 0) begin
            if (exp_ok < 65535) exp_ok++;
        end else if (status <= 5) begin
            if (exp_err < 65535) exp_err++;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (rx_state != 3'd0 && n < 400) begin
            tick();
            n++;
        end
        chk("idle_reached", rx_state, 0);
    endtask

    task automatic check_term(input string tag, input int status, input int d0, input int r0);
        model_term(status);
        chk({tag, "_done_cnt"}, done_cnt - d0, 1);
        chk({tag, "_status"}, last_status, status);
        chk({tag, "_core_rst_cycles"}, rst_hi - r0, (status <= 1) ? 0 : RST_CYCLES);
        chk({tag, "_count_ok"}, pkt_count_ok, exp_ok);
        chk({tag, "_count_err"}, pkt_count_err, exp_err);
    endtask

    task automatic do_abort(input int kind);
        if (kind == 5) begin
            tx_busy = 1'b1; tick(); tx_busy = 1'b0;
        end else if (kind == 6) begin
            cfg_enable = 1'b0; tx_busy = 1'($urandom_range(0, 1)); tick();
            cfg_enable = 1'b1; tx_busy = 1'b0;
        end
    endtask

    // kind: 0 good, 1 fcs bad, 2 bad header, 3 HT unsupported, 4 timeout, 5 tx abort,
    // 6 disable; phase picks where kinds 4..6 strike (0 wait-long, 1 wait-hdr, 2 recv).
    task automatic run_pkt(input int kind, input int phase, input int len);
        int d0 = done_cnt;
        int r0 = rst_hi;
        pulse_short(); gap();
        if (kind >= 4 && phase == 0) begin
            do_abort(kind);
        end else begin
            pulse_long(); gap();
            if (kind >= 4 && phase == 1) begin
                do_abort(kind);
            end else begin
                pulse_hdr(kind != 2, (kind == 3) || (kind == 2 && $urandom_range(0, 1) == 1),
                          16'(len));
                if (kind != 2 && kind != 3) begin
                    for (int i = 0; i < len; i++) begin
                        pulse_byte(); gap();
                    end
                    if (kind >= 4) do_abort(kind);
                    else pulse_fcs(kind == 0);
                end
            end
        end
        wait_idle();
        check_term("rand_pkt", kind, d0, r0);
        if (kind <= 1) chk("rand_len_latched", pkt_len_latched, len);
    endtask

    initial begin
        int d0, r0, n;
        rst_n = 1'b0; cfg_enable = 1'b1; cfg_timeout = 16'd1000; tx_busy = 1'b0;
        short_preamble_detected = 1'b0; long_preamble_detected = 1'b0;
        pkt_header_valid_strobe = 1'b0; pkt_header_valid = 1'b0; ht_unsupport = 1'b0;
        pkt_len = 16'd0; byte_out_strobe = 1'b0; fcs_out_strobe = 1'b0; fcs_ok = 1'b0;
        tick(2);
        chk("rst_state", rx_state, 0);
        chk("rst_core_rst", core_rst, 0);
        chk("rst_core_enable", core_enable, 0);
        chk("rst_done", pkt_done_strobe, 0);
        chk("rst_status", pkt_status, 0);
        chk("rst_len", pkt_len_latched, 0);
        chk("rst_cnt_ok", pkt_count_ok, 0);
        chk("rst_cnt_err", pkt_count_err, 0);
        rst_n = 1'b1;
        tick(2);
        chk("idle_core_enable", core_enable, 1);

        // Good packet of 100 bytes.
        d0 = done_cnt; r0 = rst_hi;
        pulse_short(); tick(2); pulse_long(); tick(1); pulse_hdr(1'b1, 1'b0, 16'd100);
        chk("good_in_recv", rx_state, 3);
        for (int i = 0; i < 100; i++) pulse_byte();
        pulse_fcs(1'b1);
        wait_idle();
        check_term("good", 0, d0, r0);
        chk("good_len", pkt_len_latched, 100);

        // Timeout in WAIT_LONG: reset entry 51 cycles after entry.
        cfg_timeout = 16'd50;
        d0 = done_cnt; r0 = rst_hi;
        pulse_short();
        chk("tmo_wait_long", rx_state, 1);
        n = 0;
        while (rx_state != 3'd4 && n < 200) begin
            tick();
            n++;
        end
        chk("tmo_latency", n, 51);
        chk("tmo_core_enable_low", core_enable, 0);
        wait_idle();
        check_term("tmo", 4, d0, r0);

        // Bad header wins over HT unsupported.
        cfg_timeout = 16'd40;
        d0 = done_cnt; r0 = rst_hi;
        pulse_short(); pulse_long(); pulse_hdr(1'b0, 1'b1, 16'd7);
        wait_idle();
        check_term("bad_hdr", 2, d0, r0);

        // tx_busy beats FCS strobe in the same RECV cycle.
        d0 = done_cnt; r0 = rst_hi;
        pulse_short(); pulse_long(); pulse_hdr(1'b1, 1'b0, 16'd3);
        pulse_byte(); pulse_byte();
        tx_busy = 1'b1; fcs_ok = 1'b1; fcs_out_strobe = 1'b1; tick();
        tx_busy = 1'b0; fcs_out_strobe = 1'b0;
        wait_idle();
        check_term("tx_vs_fcs", 5, d0, r0);

        // Short preamble during tx is ignored.
        d0 = done_cnt;
        tx_busy = 1'b1; pulse_short(); tick(2);
        chk("busy_idle_state", rx_state, 0);
        chk("busy_idle_core_enable", core_enable, 0);
        tx_busy = 1'b0; tick();
        chk("busy_idle_no_done", done_cnt - d0, 0);

        // Zero timeout never expires.
        cfg_timeout = 16'd0;
        d0 = done_cnt; r0 = rst_hi;
        pulse_short(); tick(300);
        chk("tmo0_still_waiting", rx_state, 1);
        do_abort(6);
        wait_idle();
        check_term("tmo0_disable", 6, d0, r0);

        for (int p = 0; p < 40; p++) begin
            cfg_timeout = 16'($urandom_range(20, 60));
            run_pkt(int'($urandom_range(0, 6)), int'($urandom_range(0, 2)),
                    int'($urandom_range(1, 16)));
        end

        // Error counter saturation.
        cfg_timeout = 16'd40;
        force dut.pkt_count_err = 16'hFFFF;
        pulse_short(); do_abort(5);
        wait_idle();
        release dut.pkt_count_err;
        tick();
        chk("sat_err_hold", pkt_count_err, 16'hFFFF);
        exp_err = 65535;
        d0 = done_cnt; r0 = rst_hi;
        pulse_short(); pulse_long(); do_abort(5);
        wait_idle();
        check_term("sat_err_again", 5, d0, r0);

        // Asynchronous reset mid-RECV abandons the packet.
        pulse_short(); pulse_long(); pulse_hdr(1'b1, 1'b0, 16'd9); pulse_byte();
        chk("pre_rst_recv", rx_state, 3);
        d0 = done_cnt;
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst_state", rx_state, 0);
        chk("arst_core_rst", core_rst, 0);
        chk("arst_core_enable", core_enable, 0);
        chk("arst_done", pkt_done_strobe, 0);
        chk("arst_status", pkt_status, 0);
        chk("arst_len", pkt_len_latched, 0);
        chk("arst_cnt_ok", pkt_count_ok, 0);
        chk("arst_cnt_err", pkt_count_err, 0);
        tick(2);
        rst_n = 1'b1;
        tick(4);
        chk("arst_no_done", done_cnt - d0, 0);
        chk("arst_cnt_err_after", pkt_count_err, 0);
        chk("arst_state_after", rx_state, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
